// File: rtl/fanout_broadcast_fifo_if.sv
// Bundle of the upstream stream, destination config/handshake and the
// broadcast outputs of one fanout track.
interface fanout_broadcast_fifo_if #(
  parameter int NUM_DEST   = 7,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2
);
  logic                    flush;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_DEST-1:0]     dest_en;
  logic [NUM_DEST-1:0]     dest_sel;
  logic [NUM_DEST-1:0]     dest_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [NUM_DEST-1:0]     out_valid;
  logic [$clog2(DEPTH):0]  occupancy;

  modport master (
    output flush, in_data, in_valid, dest_en, dest_sel, dest_ready,
    input  in_ready, out_data, out_valid, occupancy
  );

  modport slave (
    input  flush, in_data, in_valid, dest_en, dest_sel, dest_ready,
    output in_ready, out_data, out_valid, occupancy
  );
endinterface

// File: rtl/fanout_broadcast_fifo.sv
// Registered eager-fork stage: a small FIFO whose head word is broadcast to
// every active destination, retiring once each of them has taken it.
module fanout_broadcast_fifo #(
  parameter int NUM_DEST   = 7,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fanout_broadcast_fifo_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [NUM_DEST-1:0]   done_r;

  logic [NUM_DEST-1:0]   active_s;
  logic [NUM_DEST-1:0]   out_valid_s;
  logic [NUM_DEST-1:0]   take_s;
  logic                  nonempty_s;
  logic                  in_ready_s;
  logic                  push_s;
  logic                  retire_s;

  // Handshake decode; in_ready looks only at registered state, flush and reset
  always_comb begin
    active_s    = bus.dest_en & bus.dest_sel;
    nonempty_s  = (count_r != {CW{1'b0}});
    in_ready_s  = rst_n & (count_r < DEPTH_C) & ~bus.flush;
    push_s      = bus.in_valid & in_ready_s;
    out_valid_s = {NUM_DEST{nonempty_s}} & active_s & ~done_r;
    take_s      = out_valid_s & bus.dest_ready;
    // Inactive destinations count as satisfied, so an all-off track sinks words
    retire_s    = nonempty_s & (&(~active_s | done_r | take_s));
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = mem_r[rd_ptr_r];
  assign bus.occupancy = count_r;

  // Payload storage, cleared on reset so the shared head output is never X
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= bus.in_data;
    end
  end

  // Pointers, occupancy and per-destination acceptance tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      done_r   <= {NUM_DEST{1'b0}};
    end else if (bus.flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      done_r   <= {NUM_DEST{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (retire_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        done_r   <= {NUM_DEST{1'b0}};
      end else begin
        done_r   <= done_r | take_s;
      end
      count_r <= count_r + CW'(push_s) - CW'(retire_s);
    end
  end
endmodule

// File: tb/tb_fanout_broadcast_fifo.sv
// Directed bench for fanout_broadcast_fifo: a vector table of per-cycle
// inputs and hand-computed outputs, plus streaming and async-reset sequences.
module tb_fanout_broadcast_fifo;
  localparam int ND = 7;
  localparam int DW = 16;
  localparam int DP = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fanout_broadcast_fifo_if #(.NUM_DEST(ND), .DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  fanout_broadcast_fifo #(.NUM_DEST(ND), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] id;
    logic [ND-1:0] en;
    logic [ND-1:0] sel;
    logic [ND-1:0] rdy;
    logic          e_ir;
    logic [ND-1:0] e_ov;
    logic          chk_d;
    logic [DW-1:0] e_d;
    logic [1:0]    e_occ;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic fl, input logic iv, input logic [DW-1:0] id,
                              input logic [ND-1:0] en, input logic [ND-1:0] sel,
                              input logic [ND-1:0] rdy, input logic e_ir,
                              input logic [ND-1:0] e_ov, input logic chk_d,
                              input logic [DW-1:0] e_d, input logic [1:0] e_occ);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.en = en; v.sel = sel; v.rdy = rdy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.chk_d = chk_d; v.e_d = e_d; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [DW-1:0] id,
                       input logic [ND-1:0] en, input logic [ND-1:0] sel,
                       input logic [ND-1:0] rdy);
    bus.flush      = fl;
    bus.in_valid   = iv;
    bus.in_data    = id;
    bus.dest_en    = en;
    bus.dest_sel   = sel;
    bus.dest_ready = rdy;
  endtask

  int delivered;
  int maxocc;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 7'h00, 7'h00, 7'h00);

    // Single-word broadcast to dests 0 and 2
    vt.push_back(mk(0, 1, 16'h00AA, 7'h7F, 7'h05, 7'h05, 1, 7'h00, 0, 16'h0000, 2'd0));
    vt.push_back(mk(0, 0, 16'h0000, 7'h7F, 7'h05, 7'h05, 1, 7'h05, 1, 16'h00AA, 2'd1));
    vt.push_back(mk(0, 0, 16'h0000, 7'h7F, 7'h05, 7'h05, 1, 7'h00, 0, 16'h0000, 2'd0));
    // Staggered acceptance: dest0 first, dest1 two cycles later
    vt.push_back(mk(0, 1, 16'h1234, 7'h7F, 7'h03, 7'h00, 1, 7'h00, 0, 16'h0000, 2'd0));
    vt.push_back(mk(0, 0, 16'h0000, 7'h7F, 7'h03, 7'h01, 1, 7'h03, 1, 16'h1234, 2'd1));
    vt.push_back(mk(0, 0, 16'h0000, 7'h7F, 7'h03, 7'h01, 1, 7'h02, 1, 16'h1234, 2'd1));
    vt.push_back(mk(0, 0, 16'h0000, 7'h7F, 7'h03, 7'h02, 1, 7'h02, 1, 16'h1234, 2'd1));
    vt.push_back(mk(0, 0, 16'h0000, 7'h7F, 7'h03, 7'h00, 1, 7'h00, 0, 16'h0000, 2'd0));
    // Backpressure to full, then drain in order
    vt.push_back(mk(0, 1, 16'h0001, 7'h7F, 7'h03, 7'h00, 1, 7'h00, 0, 16'h0000, 2'd0));
    vt.push_back(mk(0, 1, 16'h0002, 7'h7F, 7'h03, 7'h00, 1, 7'h03, 1, 16'h0001, 2'd1));
    vt.push_back(mk(0, 1, 16'h0003, 7'h7F, 7'h03, 7'h00, 0, 7'h03, 1, 16'h0001, 2'd2));
    vt.push_back(mk(0, 1, 16'h0003, 7'h7F, 7'h03, 7'h03, 0, 7'h03, 1, 16'h0001, 2'd2));
    vt.push_back(mk(0, 1, 16'h0003, 7'h7F, 7'h03, 7'h03, 1, 7'h03, 1, 16'h0002, 2'd1));
    vt.push_back(mk(0, 0, 16'h0000, 7'h7F, 7'h03, 7'h03, 1, 7'h03, 1, 16'h0003, 2'd1));
    vt.push_back(mk(0, 0, 16'h0000, 7'h7F, 7'h03, 7'h03, 1, 7'h00, 0, 16'h0000, 2'd0));
    // No active destinations: word sinks after one cycle
    vt.push_back(mk(0, 1, 16'h0005, 7'h00, 7'h7F, 7'h7F, 1, 7'h00, 0, 16'h0000, 2'd0));
    vt.push_back(mk(0, 0, 16'h0000, 7'h00, 7'h7F, 7'h7F, 1, 7'h00, 0, 16'h0000, 2'd1));
    vt.push_back(mk(0, 0, 16'h0000, 7'h00, 7'h7F, 7'h7F, 1, 7'h00, 0, 16'h0000, 2'd0));
    // Flush with full FIFO and dest0 already done
    vt.push_back(mk(0, 1, 16'h000A, 7'h7F, 7'h03, 7'h00, 1, 7'h00, 0, 16'h0000, 2'd0));
    vt.push_back(mk(0, 1, 16'h000B, 7'h7F, 7'h03, 7'h00, 1, 7'h03, 1, 16'h000A, 2'd1));
    vt.push_back(mk(0, 0, 16'h0000, 7'h7F, 7'h03, 7'h01, 0, 7'h03, 1, 16'h000A, 2'd2));
    vt.push_back(mk(1, 1, 16'h000C, 7'h7F, 7'h03, 7'h02, 0, 7'h02, 1, 16'h000A, 2'd2));
    vt.push_back(mk(0, 0, 16'h0000, 7'h7F, 7'h03, 7'h00, 1, 7'h00, 0, 16'h0000, 2'd0));
    // Flush blocks push and ignores takes on a partially filled FIFO
    vt.push_back(mk(0, 1, 16'h000D, 7'h7F, 7'h03, 7'h00, 1, 7'h00, 0, 16'h0000, 2'd0));
    vt.push_back(mk(1, 1, 16'h000E, 7'h7F, 7'h03, 7'h03, 0, 7'h03, 1, 16'h000D, 2'd1));
    vt.push_back(mk(0, 0, 16'h0000, 7'h7F, 7'h03, 7'h00, 1, 7'h00, 0, 16'h0000, 2'd0));

    #2;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_occupancy", 32'(bus.occupancy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].fl, vt[i].iv, vt[i].id, vt[i].en, vt[i].sel, vt[i].rdy);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vt[i].e_ir));
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vt[i].e_ov));
      chk($sformatf("v%0d_occupancy", i), 32'(bus.occupancy), 32'(vt[i].e_occ));
      if (vt[i].chk_d) begin
        chk($sformatf("v%0d_out_data", i), 32'(bus.out_data), 32'(vt[i].e_d));
      end
      @(posedge clk);
      #1;
    end

    // Streaming: 20 words, all destinations always ready
    delivered = 0;
    maxocc    = 0;
    for (int c = 0; c < 21; c++) begin
      drive(1'b0, (c < 20), 16'(16'h0100 + c), 7'h7F, 7'h7F, 7'h7F);
      @(negedge clk);
      if (int'(bus.occupancy) > maxocc) maxocc = int'(bus.occupancy);
      if (bus.out_valid == 7'h7F) begin
        chk($sformatf("stream_data%0d", delivered), 32'(bus.out_data), 32'(16'h0100 + delivered));
        delivered++;
      end
      @(posedge clk);
      #1;
    end
    chk("stream_count", 32'(delivered), 32'd20);
    chk("stream_maxocc", 32'(maxocc), 32'd1);

    // Asynchronous reset in the middle of a cycle with a word held
    drive(1'b0, 1'b1, 16'h0077, 7'h7F, 7'h03, 7'h00);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 16'h0000, 7'h7F, 7'h03, 7'h00);
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'h03);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("async_rst_occupancy", 32'(bus.occupancy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_out_data", 32'(bus.out_data), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fanout_broadcast_fifo.md
Name: fanout_broadcast_fifo

Overview:
- Registered eager-fork stage on an interconnect track.
- Accepts one ready/valid stream and broadcasts each word to up to NUM_DEST configured destinations.
- Tracks per-destination acceptance, so destinations may take the same word on different cycles.
- Stages the word in a DEPTH-entry FIFO, which breaks the combinational ready path that a pure AND-of-readies fanout would create back to the driver.

Parameters:
- NUM_DEST, 7, number of fanout destinations.
- DATA_WIDTH, 16, payload width.
- DEPTH, 2, FIFO entries. Legal values: 2 or 4 (power of two).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous clear of FIFO contents and acceptance state.
- in_data  input  DATA_WIDTH  upstream payload.
- in_valid  input  1  upstream valid.
- in_ready  output  1  upstream ready.
- dest_en  input  NUM_DEST  per-destination config enable.
- dest_sel  input  NUM_DEST  per-destination config select bit (this track routed to that destination).
- dest_ready  input  NUM_DEST  per-destination ready.
- out_data  output  DATA_WIDTH  head-of-FIFO payload, shared by all destinations.
- out_valid  output  NUM_DEST  per-destination valid.
- occupancy  output  $clog2(DEPTH)+1  current entry count.

Behaviour:
- active[i] = dest_en[i] & dest_sel[i]. It is combinational from config. Config must be static while occupancy != 0; changing it otherwise is undefined unless accompanied by flush.
- State: storage array of DEPTH x DATA_WIDTH, wr_ptr, rd_ptr, count, and done[NUM_DEST] (destination already took the current head).
- Reset (rst_n low, async): count=0, ptrs=0, done=0. Outputs: in_ready=0 while rst_n low, then 1 from the first cycle after release; out_valid=0; occupancy=0. out_data is don't-care but must be X-free: storage resets to 0.
- in_ready = (count < DEPTH) & ~flush. It depends only on registered state and flush, never on dest_ready.
- push = in_valid & in_ready. Data is written at wr_ptr, and wr_ptr increments mod DEPTH.
- out_valid[i] = (count != 0) & active[i] & ~done[i].
- take[i] = out_valid[i] & dest_ready[i].
- retire = (count != 0) & AND over i of (~active[i] | done[i] | take[i]).
  - With no active destinations, every word retires on the cycle it becomes head (sink behaviour).
- On retire: rd_ptr increments and done clears to 0. Otherwise done[i] is set by take[i].
- count next = count + push - retire. Simultaneous push and retire keeps count unchanged.
  - When count==DEPTH, push is blocked that cycle even if retire occurs. Throughput is still one word per cycle with DEPTH>=2.
- Latency: a word pushed at edge t is visible on out_data/out_valid in cycle t+1 (one-cycle minimum).
- Ordering: strict FIFO; every active destination sees every word exactly once.
- flush=1: at the next edge count=0, ptrs=0, done=0. During the flush cycle push is suppressed (in_ready=0), and retire/take are ignored for state update. out_valid is not gated by flush in that cycle.
- rst_n asserted mid-transfer: all in-flight words are lost immediately and outputs go to their reset values asynchronously.
- occupancy = count.

Test Plan:
- Single-word broadcast: active=7'b0000101, push 0x00AA, both dest_ready=1 -> next cycle out_valid=7'b0000101, out_data=0x00AA; word retires that edge; occupancy 1->0.
- Staggered acceptance: active=7'b0000011, dest0 ready at cycle 1, dest1 ready at cycle 3 -> out_valid goes 0b11 -> 0b10 -> 0b10 -> retire after cycle 3; dest0 never sees the word twice.
- Backpressure/full: DEPTH=2, all dest_ready=0, push 0x1,0x2,0x3 -> occupancy=2, in_ready=0 after the second push; 0x3 is held upstream. After releasing readies, outputs are 0x1,0x2,0x3 in order at one per cycle.
- Streaming throughput: all active destinations always ready, in_valid constant for 20 cycles -> 20 words delivered in 21 cycles; occupancy never exceeds 1.
- No active destinations: dest_en=0, push 0x5 -> out_valid=0; word drops after one cycle; in_ready stays 1.
- Flush and async reset: with occupancy=2 and done partially set, pulse flush -> occupancy=0 and out_valid=0 next cycle. Asserting rst_n=0 mid-cycle -> out_valid=0 and in_ready=0 immediately, without waiting for a clock edge.
